fifo_gray_ptr: RTL and testbench
================================

# fifo_gray_ptr

Parametrised pointer engine for one side of the dual-clock FIFO. It holds the local binary/Gray pointer and advances it on accepted requests. It compares the pointer against the other side's Gray pointer, which arrives already synchronised, and produces a registered full flag (write side) or empty flag (read side). An optional registered occupancy level and almost-flag are also available. One instance sits in each clock domain, replacing the hand-built counter plus converter glue used so far.

## Interface
- `AW`, 4: address width; FIFO depth = 2^AW; legal range 2..16.
- `IS_WR`, 1: 1 = write side (flag = full), 0 = read side (flag = empty).
- `ALMOST_TH`, 1: almost threshold in entries; legal range 1..2^AW-1.

- `clk`  in  1  side clock
- `rst`  in  1  reset; synchronous, active-high
- `inc`  in  1  push request (write side) or pop request (read side)
- `sync_gray`  in  AW+1  other side's Gray pointer, already synchronised into `clk`
- `addr`  out  AW  RAM address, equal to `ptr_bin[AW-1:0]`
- `ptr_bin`  out  AW+1  binary pointer including the wrap bit
- `ptr_gray`  out  AW+1  registered Gray pointer, sent to the other domain's synchroniser
- `flag`  out  1  full (`IS_WR`=1) or empty (`IS_WR`=0)
- `err`  out  1  one-cycle pulse: `inc` was refused
- `level`  out  AW+1  occupancy as seen by this side; only with `FIFO_GRAY_PTR_LEVEL_EN`
- `almost`  out  1  almost-full or almost-empty; only with `FIFO_GRAY_PTR_LEVEL_EN`

## Operation
- Accept rule: `acc = inc & ~flag`.
- `bin_nxt = ptr_bin + acc`, modulo 2^(AW+1).
- `gray_nxt = bin_nxt ^ (bin_nxt >> 1)`.
- Full compare (`IS_WR`=1): `gray_nxt == {~sync_gray[AW:AW-1], sync_gray[AW-2:0]}`.
- Empty compare (`IS_WR`=0): `gray_nxt == sync_gray`.
- `err` is registered from `inc & flag`. A refused request never changes any pointer.
- Wrap-around: after 2^(AW+1) accepted increments the pointer returns to 0. Each step flips exactly one `ptr_gray` bit, including the step from 2^(AW+1)-1 back to 0.
- Reset values:
  - `ptr_bin`, `ptr_gray`, `addr`, `level`, `err` = 0.
  - `flag` = 0 on the write side, 1 on the read side.
  - `almost` = 0 on the write side, 1 on the read side.
- Reset mid-operation: all registers return to their reset values on the reset edge. `inc` and `sync_gray` are ignored while `rst` = 1.
- No separate state machine. State is the pointer register plus the registered flags.

## Timing
- Every output is registered. No combinational path runs from an input to an output.
- Accepted `inc` at edge N: `ptr_bin`, `ptr_gray` and `addr` show the new value after edge N.
- `flag` is computed from `bin_nxt`/`gray_nxt` and the current `sync_gray`, and updates at the same edge as the pointer. Example: full asserts together with the pointer value that fills the FIFO, so the next `inc` is already refused.
- A `sync_gray` change seen before edge N affects `flag`, `level` and `almost` after edge N, i.e. one cycle of latency.
- If `inc` and a `sync_gray` change arrive in the same cycle, both are used in the same next-state computation.
- Flags are pessimistic by construction: full or empty may deassert late, but never early.

## Configuration
- Macro: `FIFO_GRAY_PTR_LEVEL_EN`.
- Defined:
  - Convert `sync_gray` to binary `sbin`.
  - Write side: `level_nxt = bin_nxt - sbin`; `almost` = `level_nxt >= 2^AW - ALMOST_TH`.
  - Read side: `level_nxt = sbin - bin_nxt`; `almost` = `level_nxt <= ALMOST_TH`.
  - Subtraction is modulo 2^(AW+1). Both outputs are registered and follow the same timing as `flag`.
- Undefined: the `level` and `almost` ports and the conversion logic do not exist.

## Structure
- Shared package `fifo_pkg`:
  - typedef `ptr_t` = `logic [AW:0]`.
  - constant functions `depth(AW)` and `full_mask(AW)`.
  - a `bin2gray_f` function used for `gray_nxt`.
- Sub-module: one instance of the existing `gray2bin` (W = AW+1) on `sync_gray`, present only under `FIFO_GRAY_PTR_LEVEL_EN`.

## Test plan
- Reset, both `IS_WR` values:
  - write side reads `flag`=0, `ptr_gray`=0.
  - read side reads `flag`=1.
  - assert `rst` for 1 cycle mid-fill: pointer returns to 0 on the next edge.
- Write side, AW=2, `sync_gray`=0:
  - 4 `inc` → `flag`=1 after the 4th edge, `ptr_bin`=4, `ptr_gray`=3'b110.
  - a 5th `inc` → `err` pulses 1 cycle and `ptr_bin` stays at 4.
- Read side, AW=2: set `sync_gray`=3'b010 (binary 3):
  - `flag` falls one cycle later; `level`=3.
  - 3 `inc` → `flag`=1 with `ptr_bin`=3.
- Wrap, AW=3: 16 accepted increments → each consecutive `ptr_gray` differs in exactly 1 bit; final value 0; `addr` wraps 7→0 twice.
- Almost, write side, AW=3, ALMOST_TH=2, `sync_gray`=0:
  - `almost` asserts as `level` reaches 6.
  - `sync_gray` = Gray(2) → `level`=4 and `almost`=0 one cycle later.
- Simultaneous events, write side full at AW=2: `inc` in the same cycle `sync_gray` moves to Gray(1) → `inc` refused with `err`=1, and `flag`=0 on the next edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and helpers for the dual-clock FIFO pointer engines
package fifo_pkg;

    localparam int unsigned AW_MAX = 16;

    // Widest pointer (address plus wrap bit); narrower engines use the low AW+1 bits.
    typedef logic [AW_MAX:0] ptr_t;

    function automatic int unsigned depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    // In Gray code a pointer exactly one lap ahead differs from the other
    // pointer only in its two top bits.
    function automatic ptr_t full_mask(input int unsigned aw);
        return ptr_t'(3) << (aw - 32'd1);
    endfunction

    // Zero-extended inputs give the same low bits as a narrow conversion.
    function automatic ptr_t bin2gray_f(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray2bin.sv
// rtl/gray2bin.sv - combinational Gray to binary converter
// Ports:
//   gray  in  W  Gray-coded value
//   bin   out W  binary equivalent
module gray2bin #(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        bin = '0;
        for (int i = 0; i < W; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/fifo_gray_ptr.sv
// rtl/fifo_gray_ptr.sv - binary/Gray pointer engine with registered full or empty flag
// Optional feature macro: FIFO_GRAY_PTR_LEVEL_EN (adds level and almost outputs)
// Parameters:
//   AW         address width, depth = 2^AW (2..16)
//   IS_WR      1 = write side (flag = full), 0 = read side (flag = empty)
//   ALMOST_TH  almost threshold in entries (1..2^AW-1)
// Ports:
//   clk        in   1     side clock
//   rst        in   1     synchronous active-high reset
//   inc        in   1     push (write side) or pop (read side) request
//   sync_gray  in   AW+1  other side's Gray pointer, already synchronised
//   addr       out  AW    RAM address, ptr_bin[AW-1:0]
//   ptr_bin    out  AW+1  binary pointer with wrap bit
//   ptr_gray   out  AW+1  registered Gray pointer for the other domain
//   flag       out  1     full or empty
//   err        out  1     one-cycle pulse when inc was refused
//   level      out  AW+1  occupancy seen by this side (macro only)
//   almost     out  1     almost-full or almost-empty (macro only)
module fifo_gray_ptr
    import fifo_pkg::*;
#(
    parameter int unsigned AW        = 4,
    parameter bit          IS_WR     = 1'b1,
    parameter int unsigned ALMOST_TH = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic [AW:0]   sync_gray,
    output logic [AW-1:0] addr,
    output logic [AW:0]   ptr_bin,
    output logic [AW:0]   ptr_gray,
    output logic          flag,
    output logic          err
`ifdef FIFO_GRAY_PTR_LEVEL_EN
    ,
    output logic [AW:0]   level,
    output logic          almost
`endif
);

    localparam int unsigned PW = AW + 1;

    logic        acc;
    logic [AW:0] bin_nxt;
    logic [AW:0] gray_nxt;
    logic        flag_nxt;

    // A refused request leaves bin_nxt equal to ptr_bin, so no pointer moves.
    assign acc      = inc & ~flag;
    assign bin_nxt  = ptr_bin + PW'(acc);
    assign gray_nxt = PW'(bin2gray_f(ptr_t'(bin_nxt)));
    assign addr     = ptr_bin[AW-1:0];

    // Flags compare the next pointer so they switch on the same edge as the
    // pointer that causes them, and the next request is refused at once.
    if (IS_WR) begin : g_full
        localparam logic [AW:0] FULL_MASK = PW'(full_mask(AW));
        assign flag_nxt = (gray_nxt == (sync_gray ^ FULL_MASK));
    end else begin : g_empty
        assign flag_nxt = (gray_nxt == sync_gray);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_bin  <= '0;
            ptr_gray <= '0;
            flag     <= !IS_WR;
            err      <= 1'b0;
        end else begin
            ptr_bin  <= bin_nxt;
            ptr_gray <= gray_nxt;
            flag     <= flag_nxt;
            err      <= inc & flag;
        end
    end

`ifdef FIFO_GRAY_PTR_LEVEL_EN
    logic [AW:0] sbin;
    logic [AW:0] level_nxt;
    logic        almost_nxt;

    gray2bin #(
        .W (PW)
    ) u_gray2bin (
        .gray (sync_gray),
        .bin  (sbin)
    );

    // Modulo-2^(AW+1) subtraction yields the occupancy across the wrap.
    if (IS_WR) begin : g_level_wr
        localparam logic [AW:0] ALMOST_LVL = PW'(depth(AW) - ALMOST_TH);
        assign level_nxt  = bin_nxt - sbin;
        assign almost_nxt = (level_nxt >= ALMOST_LVL);
    end else begin : g_level_rd
        localparam logic [AW:0] ALMOST_LVL = PW'(ALMOST_TH);
        assign level_nxt  = sbin - bin_nxt;
        assign almost_nxt = (level_nxt <= ALMOST_LVL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level  <= '0;
            almost <= !IS_WR;
        end else begin
            level  <= level_nxt;
            almost <= almost_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_gray_ptr.sv
// tb/tb_fifo_gray_ptr.sv - directed self-checking bench for fifo_gray_ptr
module tb_fifo_gray_ptr;

    logic clk;
    logic rst;

    logic       wr2_inc;
    logic [2:0] wr2_sync;
    logic [1:0] wr2_addr;
    logic [2:0] wr2_bin, wr2_gray;
    logic       wr2_flag, wr2_err;

    logic       rd2_inc;
    logic [2:0] rd2_sync;
    logic [1:0] rd2_addr;
    logic [2:0] rd2_bin, rd2_gray;
    logic       rd2_flag, rd2_err;

    logic       wr3_inc;
    logic [3:0] wr3_sync;
    logic [2:0] wr3_addr;
    logic [3:0] wr3_bin, wr3_gray;
    logic       wr3_flag, wr3_err;

`ifdef FIFO_GRAY_PTR_LEVEL_EN
    logic [2:0] wr2_level, rd2_level;
    logic [3:0] wr3_level;
    logic       wr2_almost, rd2_almost, wr3_almost;
`endif

    int checks = 0;
    int errors = 0;

    fifo_gray_ptr #(.AW(2), .IS_WR(1'b1), .ALMOST_TH(1)) u_wr2 (
        .clk(clk), .rst(rst), .inc(wr2_inc), .sync_gray(wr2_sync),
        .addr(wr2_addr), .ptr_bin(wr2_bin), .ptr_gray(wr2_gray),
        .flag(wr2_flag), .err(wr2_err)
`ifdef FIFO_GRAY_PTR_LEVEL_EN
        , .level(wr2_level), .almost(wr2_almost)
`endif
    );

    fifo_gray_ptr #(.AW(2), .IS_WR(1'b0), .ALMOST_TH(1)) u_rd2 (
        .clk(clk), .rst(rst), .inc(rd2_inc), .sync_gray(rd2_sync),
        .addr(rd2_addr), .ptr_bin(rd2_bin), .ptr_gray(rd2_gray),
        .flag(rd2_flag), .err(rd2_err)
`ifdef FIFO_GRAY_PTR_LEVEL_EN
        , .level(rd2_level), .almost(rd2_almost)
`endif
    );

    fifo_gray_ptr #(.AW(3), .IS_WR(1'b1), .ALMOST_TH(2)) u_wr3 (
        .clk(clk), .rst(rst), .inc(wr3_inc), .sync_gray(wr3_sync),
        .addr(wr3_addr), .ptr_bin(wr3_bin), .ptr_gray(wr3_gray),
        .flag(wr3_flag), .err(wr3_err)
`ifdef FIFO_GRAY_PTR_LEVEL_EN
        , .level(wr3_level), .almost(wr3_almost)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] gray4(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr2_inc = 1'b0; rd2_inc = 1'b0; wr3_inc = 1'b0;
        wr2_sync = '0;  rd2_sync = '0;  wr3_sync = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (wr2_flag !== 1'b0) begin errors++; $display("FAIL rst_wr_flag got %0b exp 0", wr2_flag); end
        checks++; if (wr2_gray !== 3'd0) begin errors++; $display("FAIL rst_wr_gray got %0h exp 0", wr2_gray); end
        checks++; if (wr2_bin !== 3'd0) begin errors++; $display("FAIL rst_wr_bin got %0h exp 0", wr2_bin); end
        checks++; if (wr2_err !== 1'b0) begin errors++; $display("FAIL rst_wr_err got %0b exp 0", wr2_err); end
        checks++; if (rd2_flag !== 1'b1) begin errors++; $display("FAIL rst_rd_flag got %0b exp 1", rd2_flag); end
        checks++; if (rd2_bin !== 3'd0) begin errors++; $display("FAIL rst_rd_bin got %0h exp 0", rd2_bin); end
`ifdef FIFO_GRAY_PTR_LEVEL_EN
        checks++; if (wr3_level !== 4'd0) begin errors++; $display("FAIL rst_wr_level got %0h exp 0", wr3_level); end
        checks++; if (wr3_almost !== 1'b0) begin errors++; $display("FAIL rst_wr_almost got %0b exp 0", wr3_almost); end
        checks++; if (rd2_almost !== 1'b1) begin errors++; $display("FAIL rst_rd_almost got %0b exp 1", rd2_almost); end
`endif
        // Mid-fill reset, with inc and sync_gray held active during reset.
        wr2_inc = 1'b1;
        tick();
        tick();
        checks++; if (wr2_bin !== 3'd2) begin errors++; $display("FAIL midfill_bin got %0h exp 2", wr2_bin); end
        rst = 1'b1;
        wr2_sync = 3'b011;
        tick();
        checks++; if (wr2_bin !== 3'd0) begin errors++; $display("FAIL midrst_bin got %0h exp 0", wr2_bin); end
        checks++; if (wr2_gray !== 3'd0) begin errors++; $display("FAIL midrst_gray got %0h exp 0", wr2_gray); end
        checks++; if (wr2_addr !== 2'd0) begin errors++; $display("FAIL midrst_addr got %0h exp 0", wr2_addr); end
        rst = 1'b0;
        wr2_inc = 1'b0;
        wr2_sync = '0;
    endtask

    task automatic test_write_full();
        do_reset();
        wr2_inc = 1'b1;
        tick(); tick(); tick();
        checks++; if (wr2_flag !== 1'b0) begin errors++; $display("FAIL full_early got %0b exp 0", wr2_flag); end
        checks++; if (wr2_bin !== 3'd3) begin errors++; $display("FAIL full_bin3 got %0h exp 3", wr2_bin); end
        tick();
        checks++; if (wr2_flag !== 1'b1) begin errors++; $display("FAIL full_flag got %0b exp 1", wr2_flag); end
        checks++; if (wr2_bin !== 3'd4) begin errors++; $display("FAIL full_bin got %0h exp 4", wr2_bin); end
        checks++; if (wr2_gray !== 3'b110) begin errors++; $display("FAIL full_gray got %0b exp 110", wr2_gray); end
        checks++; if (wr2_err !== 1'b0) begin errors++; $display("FAIL full_err0 got %0b exp 0", wr2_err); end
        tick();
        checks++; if (wr2_err !== 1'b1) begin errors++; $display("FAIL refuse_err got %0b exp 1", wr2_err); end
        checks++; if (wr2_bin !== 3'd4) begin errors++; $display("FAIL refuse_bin got %0h exp 4", wr2_bin); end
        wr2_inc = 1'b0;
        tick();
        checks++; if (wr2_err !== 1'b0) begin errors++; $display("FAIL err_pulse got %0b exp 0", wr2_err); end
        checks++; if (wr2_flag !== 1'b1) begin errors++; $display("FAIL full_hold got %0b exp 1", wr2_flag); end
    endtask

    task automatic test_simultaneous();
        // Continues from a full write side at ptr_bin=4, sync_gray=0.
        wr2_inc = 1'b1;
        wr2_sync = 3'b001;
        tick();
        checks++; if (wr2_err !== 1'b1) begin errors++; $display("FAIL simul_err got %0b exp 1", wr2_err); end
        checks++; if (wr2_flag !== 1'b0) begin errors++; $display("FAIL simul_flag got %0b exp 0", wr2_flag); end
        checks++; if (wr2_bin !== 3'd4) begin errors++; $display("FAIL simul_bin got %0h exp 4", wr2_bin); end
`ifdef FIFO_GRAY_PTR_LEVEL_EN
        checks++; if (wr2_level !== 3'd3) begin errors++; $display("FAIL simul_level got %0h exp 3", wr2_level); end
`endif
        tick();
        checks++; if (wr2_bin !== 3'd5) begin errors++; $display("FAIL refill_bin got %0h exp 5", wr2_bin); end
        checks++; if (wr2_flag !== 1'b1) begin errors++; $display("FAIL refill_flag got %0b exp 1", wr2_flag); end
        checks++; if (wr2_err !== 1'b0) begin errors++; $display("FAIL refill_err got %0b exp 0", wr2_err); end
        wr2_inc = 1'b0;
    endtask

    task automatic test_read_empty();
        do_reset();
        rd2_sync = 3'b010;
        checks++; if (rd2_flag !== 1'b1) begin errors++; $display("FAIL rd_latency got %0b exp 1", rd2_flag); end
        tick();
        checks++; if (rd2_flag !== 1'b0) begin errors++; $display("FAIL rd_flag_fall got %0b exp 0", rd2_flag); end
`ifdef FIFO_GRAY_PTR_LEVEL_EN
        checks++; if (rd2_level !== 3'd3) begin errors++; $display("FAIL rd_level3 got %0h exp 3", rd2_level); end
        checks++; if (rd2_almost !== 1'b0) begin errors++; $display("FAIL rd_almost3 got %0b exp 0", rd2_almost); end
`endif
        rd2_inc = 1'b1;
        tick();
        tick();
        checks++; if (rd2_flag !== 1'b0) begin errors++; $display("FAIL rd_early got %0b exp 0", rd2_flag); end
`ifdef FIFO_GRAY_PTR_LEVEL_EN
        checks++; if (rd2_level !== 3'd1) begin errors++; $display("FAIL rd_level1 got %0h exp 1", rd2_level); end
        checks++; if (rd2_almost !== 1'b1) begin errors++; $display("FAIL rd_almost1 got %0b exp 1", rd2_almost); end
`endif
        tick();
        checks++; if (rd2_flag !== 1'b1) begin errors++; $display("FAIL rd_empty got %0b exp 1", rd2_flag); end
        checks++; if (rd2_bin !== 3'd3) begin errors++; $display("FAIL rd_bin got %0h exp 3", rd2_bin); end
        checks++; if (rd2_addr !== 2'd3) begin errors++; $display("FAIL rd_addr got %0h exp 3", rd2_addr); end
        tick();
        checks++; if (rd2_err !== 1'b1) begin errors++; $display("FAIL rd_refuse_err got %0b exp 1", rd2_err); end
        checks++; if (rd2_bin !== 3'd3) begin errors++; $display("FAIL rd_refuse_bin got %0h exp 3", rd2_bin); end
        rd2_inc = 1'b0;
    endtask

    task automatic test_wrap();
        logic [3:0] model;
        logic [3:0] prev_gray;
        logic [2:0] prev_addr;
        int         wraps;
        do_reset();
        model = '0;
        prev_gray = '0;
        prev_addr = '0;
        wraps = 0;
        for (int i = 0; i < 16; i++) begin
            // Reader tracks the writer so the FIFO never fills.
            wr3_sync = gray4(model);
            wr3_inc = 1'b1;
            tick();
            model = model + 4'd1;
            checks++; if (wr3_gray !== gray4(model)) begin errors++; $display("FAIL wrap_gray step %0d got %0h exp %0h", i, wr3_gray, gray4(model)); end
            checks++; if ($countones(wr3_gray ^ prev_gray) != 1) begin errors++; $display("FAIL wrap_onebit step %0d got %0h exp one bit from %0h", i, wr3_gray, prev_gray); end
            if (prev_addr == 3'd7 && wr3_addr == 3'd0) wraps++;
            prev_addr = wr3_addr;
            prev_gray = gray4(model);
        end
        wr3_inc = 1'b0;
        checks++; if (wr3_bin !== 4'd0) begin errors++; $display("FAIL wrap_bin got %0h exp 0", wr3_bin); end
        checks++; if (wr3_gray !== 4'd0) begin errors++; $display("FAIL wrap_final_gray got %0h exp 0", wr3_gray); end
        checks++; if (wraps != 2) begin errors++; $display("FAIL wrap_addr_count got %0d exp 2", wraps); end
    endtask

`ifdef FIFO_GRAY_PTR_LEVEL_EN
    task automatic test_almost();
        logic exp_almost;
        do_reset();
        wr3_inc = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            exp_almost = (i >= 6);
            checks++; if (wr3_level !== 4'(i)) begin errors++; $display("FAIL almost_level step %0d got %0h exp %0h", i, wr3_level, i); end
            checks++; if (wr3_almost !== exp_almost) begin errors++; $display("FAIL almost_flag step %0d got %0b exp %0b", i, wr3_almost, exp_almost); end
        end
        wr3_inc = 1'b0;
        wr3_sync = 4'b0011;
        tick();
        checks++; if (wr3_level !== 4'd4) begin errors++; $display("FAIL almost_drain_level got %0h exp 4", wr3_level); end
        checks++; if (wr3_almost !== 1'b0) begin errors++; $display("FAIL almost_drain got %0b exp 0", wr3_almost); end
        checks++; if (wr3_flag !== 1'b0) begin errors++; $display("FAIL almost_full got %0b exp 0", wr3_flag); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        wr2_inc = 1'b0; rd2_inc = 1'b0; wr3_inc = 1'b0;
        wr2_sync = '0;  rd2_sync = '0;  wr3_sync = '0;
        test_reset();
        test_write_full();
        test_simultaneous();
        test_read_empty();
        test_wrap();
`ifdef FIFO_GRAY_PTR_LEVEL_EN
        test_almost();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
